fp_prealign_stage: RTL and testbench
====================================

Name: fp_prealign_stage

Overview:
- Parametrised, registered front-end stage for the floating-point unit.
- Unpacks two IEEE-style operands and computes everything the aligner needs: magnitude ordering/swap, saturated alignment shift, effective operation, result sign, mantissa compare and mul/div pre-exponent.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the stage can sit in a stalling pipeline between the operand issue logic and the alignment shifter.

Parameters:
EXP_W, 8, exponent width; BIAS = 2^(EXP_W-1)-1 derived internally
FRAC_W, 23, fraction width; MANT_W = FRAC_W+1 and DATA_W = 1+EXP_W+FRAC_W derived internally
SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W > FRAC_W+4

Ports:
Clk  input  1  rising-edge clock
ResetN  input  1  asynchronous active-low reset
InValid  input  1  operand pair valid
InReady  output  1  stage can accept; registered
Operand1  input  DATA_W  first operand
Operand2  input  DATA_W  second operand
Operation  input  2  00 add, 01 sub, 10 mul, 11 div
OutValid  output  1  result valid
OutReady  input  1  downstream accepts
OutBigExp  output  EXP_W  effective exponent of larger-magnitude operand
OutBigMant  output  MANT_W  mantissa of larger operand
OutSmallMant  output  MANT_W  mantissa of smaller operand
OutShift  output  SHAMT_W  right-shift for small mantissa; saturated
OutSwapped  output  1  1 = Operand2 is the larger magnitude
OutEffSub  output  1  effective subtraction (add/sub only)
OutSign  output  1  result sign
OutZeroDiff  output  1  exponents equal
OutCompare  output  2  mantissa compare: 00 equal, 01 M1>M2, 10 M1<M2
OutExactCancel  output  1  effective subtract with identical magnitudes
OutMDExponent  output  EXP_W+2  signed: E1+E2-BIAS (mul) or E1-E2+BIAS (div)
OutSpecial  output  4  {NaN1|NaN2, Inf1, Inf2, Zero1|Zero2}

Behaviour:
- Reset (async, ResetN=0):
  - OutValid=0, InReady=1.
  - Skid entry empty.
  - All data outputs 0.
  - Takes effect immediately, including mid-transfer; any in-flight data is dropped.
- Handshake:
  - Input transfer when InValid&InReady; output transfer when OutValid&OutReady.
  - Latency is 1 cycle.
  - Throughput is 1 per cycle while OutReady=1.
- Buffering (main output register plus one skid register):
  - If the output is stalled and a transfer arrives, the data goes to skid and InReady falls next cycle.
  - When the output drains, skid moves to main and InReady rises next cycle.
  - Order is preserved; no loss, no duplication.
  - Data inputs are ignored when InValid=0.
- Unpack: sign = MSB; exponent = next EXP_W bits; mantissa = {hidden, fraction}, hidden=1 for nonzero exponent.
- Ordering:
  - Swap when E2>E1, or when E1==E2 and M2>M1.
  - Big/Small outputs follow the swap.
- Shift: |E1-E2|, saturated to FRAC_W+4 (27 by default).
- OutEffSub = Operation[0] ^ S1 ^ S2 for add/sub; 0 for mul/div.
- OutSign:
  - add/sub: swapped ? S2^Operation[0] : S1; forced 0 when OutExactCancel.
  - mul/div: S1^S2.
- OutMDExponent: computed in EXP_W+2-bit two's complement, with no wrap inside that width.
- Special classification:
  - exp all-ones with fraction≠0 is NaN; exp all-ones with fraction=0 is Inf.
  - exp 0 with fraction 0 is zero.
  - Pass-through flags only; all other outputs are still computed.

Optional Feature:
FP_SUBNORMAL_EN
- Defined: an exponent-0 operand has hidden bit 0 and effective exponent 1 in shift/ordering/MD arithmetic.
- Undefined: an exponent-0 operand is flushed to zero (mantissa 0, exponent 0, sign kept) and OutSpecial[0] is set.

Test Plan:
- 0x3F800000 + 0x40000000, add → OutSwapped=1, OutShift=1, OutBigExp=0x80, OutBigMant=OutSmallMant=0x800000, OutEffSub=0, OutSign=0.
- 0x40400000 − 0x40400000 → OutEffSub=1, OutZeroDiff=1, OutCompare=00, OutExactCancel=1, OutSign=0.
- 0x3F800000 + 0x4F800000 (exponent diff 32) → OutShift=27, OutSwapped=1.
- 0x40000000 mul 0x40800000 → OutMDExponent=130, OutSign=0, OutEffSub=0.
- OutReady=0 while 3 back-to-back valid inputs are driven → 2 accepted, InReady=0 on the 3rd. Release OutReady → all 3 outputs emerge in order, then InReady=1.
- ResetN pulsed low while OutValid=1 → OutValid=0 and InReady=1 asynchronously.
- Operand1=0x00000001 + 0x00000000 → macro defined: BigMant=0x000001, BigExp=1. Macro undefined: OutSpecial[0]=1, mantissas 0.

Source files
------------

// File: rtl/fp_prealign_stage.sv
// Floating-point pre-alignment stage: unpacks two operands, orders them by magnitude and
// registers everything the aligner needs behind a 2-entry skid buffer. Macro: FP_SUBNORMAL_EN.
module fp_prealign_stage #(
    parameter  int EXP_W   = 8,
    parameter  int FRAC_W  = 23,
    parameter  int SHAMT_W = 5,
    localparam int DATA_W  = 1 + EXP_W + FRAC_W,
    localparam int MANT_W  = FRAC_W + 1
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [DATA_W-1:0]       Operand1,
    input  logic [DATA_W-1:0]       Operand2,
    input  logic [1:0]              Operation,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [EXP_W-1:0]        OutBigExp,
    output logic [MANT_W-1:0]       OutBigMant,
    output logic [MANT_W-1:0]       OutSmallMant,
    output logic [SHAMT_W-1:0]      OutShift,
    output logic                    OutSwapped,
    output logic                    OutEffSub,
    output logic                    OutSign,
    output logic                    OutZeroDiff,
    output logic [1:0]              OutCompare,
    output logic                    OutExactCancel,
    output logic signed [EXP_W+1:0] OutMDExponent,
    output logic [3:0]              OutSpecial
);

    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int SAT  = FRAC_W + 4;
    localparam logic signed [EXP_W+1:0] BIAS_X = BIAS[EXP_W+1:0];
    localparam logic [EXP_W:0]          SAT_E  = SAT[EXP_W:0];
    localparam logic [SHAMT_W-1:0]      SAT_S  = SAT[SHAMT_W-1:0];
    localparam logic [EXP_W-1:0]        EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam int PAY_W = EXP_W + 2*MANT_W + SHAMT_W + 4 + 2 + 1 + (EXP_W+2) + 4;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic              nan;
        logic              inf;
        logic              zero;
    } op_t;

    function automatic op_t unpack(input logic [DATA_W-1:0] x);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        op_t               u;
        e     = x[DATA_W-2 -: EXP_W];
        f     = x[FRAC_W-1:0];
        u.s   = x[DATA_W-1];
        u.nan = (&e) && (|f);
        u.inf = (&e) && !(|f);
`ifdef FP_SUBNORMAL_EN
        // Subnormals keep their fraction and sit at the minimum normal exponent.
        u.e    = (e == '0) ? EXP_ONE : e;
        u.m    = {|e, f};
        u.zero = (e == '0) && (f == '0);
`else
        // Without subnormal support an exponent-0 operand is a signed zero.
        u.e    = e;
        u.m    = (e == '0) ? '0 : {1'b1, f};
        u.zero = (e == '0);
`endif
        return u;
    endfunction

    function automatic logic [SHAMT_W-1:0] sat_shift(input logic [EXP_W-1:0] d);
        if ({1'b0, d} > SAT_E)
            return SAT_S;
        return d[SHAMT_W-1:0];
    endfunction

    op_t                     w_o1;
    op_t                     w_o2;
    logic                    w_swap;
    logic                    w_eff_sub;
    logic                    w_exact;
    logic                    w_sign;
    logic                    w_zero_diff;
    logic [1:0]              w_cmp;
    logic [EXP_W-1:0]        w_diff;
    logic [EXP_W-1:0]        w_big_exp;
    logic [MANT_W-1:0]       w_big_mant;
    logic [MANT_W-1:0]       w_small_mant;
    logic signed [EXP_W+1:0] w_e1x;
    logic signed [EXP_W+1:0] w_e2x;
    logic signed [EXP_W+1:0] w_md;
    logic [3:0]              w_special;
    logic [PAY_W-1:0]        w_payload;
    logic                    w_in_xfer;
    logic                    w_out_free;

    assign w_o1 = unpack(Operand1);
    assign w_o2 = unpack(Operand2);

    assign w_swap       = (w_o2.e > w_o1.e) || ((w_o2.e == w_o1.e) && (w_o2.m > w_o1.m));
    assign w_zero_diff  = (w_o1.e == w_o2.e);
    assign w_diff       = w_swap ? (w_o2.e - w_o1.e) : (w_o1.e - w_o2.e);
    assign w_big_exp    = w_swap ? w_o2.e : w_o1.e;
    assign w_big_mant   = w_swap ? w_o2.m : w_o1.m;
    assign w_small_mant = w_swap ? w_o1.m : w_o2.m;
    assign w_cmp        = (w_o1.m == w_o2.m) ? 2'b00 : ((w_o1.m > w_o2.m) ? 2'b01 : 2'b10);

    assign w_eff_sub = !Operation[1] && (Operation[0] ^ w_o1.s ^ w_o2.s);
    assign w_exact   = w_eff_sub && w_zero_diff && (w_o1.m == w_o2.m);
    assign w_sign    = Operation[1] ? (w_o1.s ^ w_o2.s)
                     : (w_exact ? 1'b0 : (w_swap ? (w_o2.s ^ Operation[0]) : w_o1.s));

    // Two guard bits above the exponent keep E1+E2-BIAS and E1-E2+BIAS from wrapping.
    assign w_e1x = signed'({2'b00, w_o1.e});
    assign w_e2x = signed'({2'b00, w_o2.e});
    assign w_md  = Operation[0] ? (w_e1x - w_e2x + BIAS_X) : (w_e1x + w_e2x - BIAS_X);

    assign w_special = {w_o1.nan | w_o2.nan, w_o1.inf, w_o2.inf, w_o1.zero | w_o2.zero};

    assign w_payload = {w_big_exp, w_big_mant, w_small_mant, sat_shift(w_diff), w_swap,
                        w_eff_sub, w_sign, w_zero_diff, w_cmp, w_exact, w_md, w_special};

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [PAY_W-1:0] r_main;
    logic [PAY_W-1:0] r_skid;

    assign w_in_xfer  = InValid && r_in_ready;
    assign w_out_free = !r_out_valid || OutReady;

    // Skid entry absorbs the one transfer accepted while the output was stalled.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_xfer) begin
                r_main      <= w_payload;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid       <= w_payload;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign InReady  = r_in_ready;
    assign OutValid = r_out_valid;
    assign {OutBigExp, OutBigMant, OutSmallMant, OutShift, OutSwapped, OutEffSub, OutSign,
            OutZeroDiff, OutCompare, OutExactCancel, OutMDExponent, OutSpecial} = r_main;

endmodule

// File: tb/tb_fp_prealign_stage.sv
// Directed scoreboard bench for fp_prealign_stage (default parameters, binary32 operands).
module tb_fp_prealign_stage;

    logic              Clk = 1'b0;
    logic              ResetN = 1'b0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic [31:0]       Operand1 = '0;
    logic [31:0]       Operand2 = '0;
    logic [1:0]        Operation = 2'b00;
    logic              OutValid;
    logic              OutReady = 1'b1;
    logic [7:0]        OutBigExp;
    logic [23:0]       OutBigMant;
    logic [23:0]       OutSmallMant;
    logic [4:0]        OutShift;
    logic              OutSwapped;
    logic              OutEffSub;
    logic              OutSign;
    logic              OutZeroDiff;
    logic [1:0]        OutCompare;
    logic              OutExactCancel;
    logic signed [9:0] OutMDExponent;
    logic [3:0]        OutSpecial;

    always #5 Clk = ~Clk;

    fp_prealign_stage dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Operand1(Operand1), .Operand2(Operand2), .Operation(Operation),
        .OutValid(OutValid), .OutReady(OutReady), .OutBigExp(OutBigExp),
        .OutBigMant(OutBigMant), .OutSmallMant(OutSmallMant), .OutShift(OutShift),
        .OutSwapped(OutSwapped), .OutEffSub(OutEffSub), .OutSign(OutSign),
        .OutZeroDiff(OutZeroDiff), .OutCompare(OutCompare), .OutExactCancel(OutExactCancel),
        .OutMDExponent(OutMDExponent), .OutSpecial(OutSpecial)
    );

    typedef struct packed {
        logic [7:0]  bexp;
        logic [23:0] bmant;
        logic [23:0] smant;
        logic [4:0]  shift;
        logic        swapped;
        logic        effsub;
        logic        sign;
        logic        zdiff;
        logic [1:0]  cmp;
        logic        exact;
        logic [9:0]  md;
        logic [3:0]  special;
    } res_t;

    res_t obs;
    assign obs = {OutBigExp, OutBigMant, OutSmallMant, OutShift, OutSwapped, OutEffSub, OutSign,
                  OutZeroDiff, OutCompare, OutExactCancel, OutMDExponent, OutSpecial};

    res_t q[$];
    res_t mon_exp;
    int   n_assert = 0;
    int   n_fail   = 0;

    res_t v1, v2, v3, v4, v5, v6, v7, v8, v9, vzero;
    int   waits;

    always @(negedge Clk) begin
        if (ResetN === 1'b1 && OutValid === 1'b1 && OutReady === 1'b1) begin
            n_assert++;
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_output observed=%h required=none", obs);
            end else begin
                mon_exp = q.pop_front();
                assert (obs === mon_exp) else begin
                    n_fail++;
                    $error("FAIL out_data observed=%h required=%h", obs, mon_exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", tag, o, e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input res_t e, output int w);
        bit done;
        done = 1'b0;
        w = 0;
        Operand1 = a;
        Operand2 = b;
        Operation = op;
        InValid = 1'b1;
        while (!done) begin
            @(negedge Clk);
            if (InReady === 1'b1) begin
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge Clk);
            #1;
            if (!done) begin
                w++;
                if (w > 50) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL accept_timeout observed=%0d required=<=50", w);
                    done = 1'b1;
                end
            end
        end
        InValid = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        Operation = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v1 = '{8'h80, 24'h800000, 24'h800000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd128, 4'b0000};
        v2 = '{8'h80, 24'hC00000, 24'hC00000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 10'd127, 4'b0000};
        v3 = '{8'h9F, 24'h800000, 24'h800000, 5'd27, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd159, 4'b0000};
        v4 = '{8'h81, 24'h800000, 24'h800000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd130, 4'b0000};
        v5 = '{8'h81, 24'hA00000, 24'hC00000, 5'd1,  1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 10'd130, 4'b0000};
        v6 = '{8'h80, 24'h800000, 24'h800000, 5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 10'd126, 4'b0000};
        v7 = '{8'hFF, 24'hC00000, 24'h800000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 10'd383, 4'b1010};
`ifdef FP_SUBNORMAL_EN
        v8 = '{8'h01, 24'h000001, 24'h000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 10'h383, 4'b0001};
`else
        v8 = '{8'h00, 24'h000000, 24'h000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 10'h381, 4'b0001};
`endif
        v9 = '{8'h80, 24'hC00000, 24'hC00000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 10'd129, 4'b0000};
        vzero = '0;

        // Reset state
        #12;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        n_assert++;
        assert (obs === vzero) else begin
            n_fail++;
            $error("FAIL rst_data observed=%h required=%h", obs, vzero);
        end
        @(negedge Clk);
        ResetN = 1'b1;
        @(posedge Clk);
        #1;

        // Directed vectors at full throughput
        send(32'h3F800000, 32'h40000000, 2'b00, v1, waits);
        send(32'h40400000, 32'h40400000, 2'b01, v2, waits);
        send(32'h3F800000, 32'h4F800000, 2'b00, v3, waits);
        send(32'h40000000, 32'h40800000, 2'b10, v4, waits);
        check("tput_wait_mul", 32'(waits), 32'd0);
        send(32'hC0A00000, 32'h40400000, 2'b00, v5, waits);
        check("tput_wait_add", 32'(waits), 32'd0);
        send(32'hBF800000, 32'h40000000, 2'b11, v6, waits);
        check("tput_wait_div", 32'(waits), 32'd0);
        send(32'h7FC00000, 32'h7F800000, 2'b00, v7, waits);
        send(32'h00000001, 32'h00000000, 2'b00, v8, waits);
        send(32'hC0400000, 32'h40400000, 2'b00, v9, waits);
        repeat (4) @(posedge Clk);
        #1;
        check("drain_directed", 32'(q.size()), 32'd0);

        // Backpressure: two accepted, third held off until the output drains
        OutReady = 1'b0;
        send(32'h3F800000, 32'h40000000, 2'b00, v1, waits);
        send(32'h40400000, 32'h40400000, 2'b01, v2, waits);
        check("bp_inready_full", 32'(InReady), 32'd0);
        check("bp_outvalid", 32'(OutValid), 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        check("bp_inready_held", 32'(InReady), 32'd0);
        check("bp_queue_held", 32'(q.size()), 32'd2);
        OutReady = 1'b1;
        send(32'h3F800000, 32'h4F800000, 2'b00, v3, waits);
        check("bp_third_waited", 32'(waits > 0), 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        check("bp_drained", 32'(q.size()), 32'd0);
        check("bp_inready_back", 32'(InReady), 32'd1);

        // Asynchronous reset in the middle of a stalled transfer
        OutReady = 1'b0;
        send(32'h40000000, 32'h40800000, 2'b10, v4, waits);
        send(32'hC0A00000, 32'h40400000, 2'b00, v5, waits);
        #2;
        ResetN = 1'b0;
        #1;
        check("arst_outvalid", 32'(OutValid), 32'd0);
        check("arst_inready", 32'(InReady), 32'd1);
        n_assert++;
        assert (obs === vzero) else begin
            n_fail++;
            $error("FAIL arst_data observed=%h required=%h", obs, vzero);
        end
        q.delete();
        @(negedge Clk);
        ResetN = 1'b1;
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        check("arst_no_output", 32'(OutValid), 32'd0);

        // Random output stalls: ordering through the skid entry
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge Clk);
                    #1;
                    OutReady = 1'($urandom_range(0, 1));
                end
                OutReady = 1'b1;
            end
        join_none
        send(32'h3F800000, 32'h40000000, 2'b00, v1, waits);
        send(32'h40400000, 32'h40400000, 2'b01, v2, waits);
        send(32'h3F800000, 32'h4F800000, 2'b00, v3, waits);
        send(32'h40000000, 32'h40800000, 2'b10, v4, waits);
        send(32'hC0A00000, 32'h40400000, 2'b00, v5, waits);
        send(32'hBF800000, 32'h40000000, 2'b11, v6, waits);
        send(32'h7FC00000, 32'h7F800000, 2'b00, v7, waits);
        send(32'h00000001, 32'h00000000, 2'b00, v8, waits);
        send(32'hC0400000, 32'h40400000, 2'b00, v9, waits);
        begin
            int w;
            w = 0;
            while (q.size() != 0 && w < 200) begin
                @(posedge Clk);
                w++;
            end
        end
        repeat (70) @(posedge Clk);
        #1;
        check("stall_drained", 32'(q.size()), 32'd0);
        check("stall_idle", 32'(OutValid), 32'd0);
        check("stall_inready", 32'(InReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
